// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first over WIDTH cycles
// with a single borrow flip-flop, framed by valid/ready handshakes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_lastShift;
  logic             w_diffBit;
  logic             w_borrowNext;

  assign w_lastShift = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_diffBit    = r_aSh[0] ^ r_bSh[0] ^ r_borrow;
    w_borrowNext = (~r_aSh[0] & r_bSh[0]) | (~(r_aSh[0] ^ r_bSh[0]) & r_borrow);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = SHIFT;
      SHIFT:   if (w_lastShift) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: operands load on accept, then one difference bit per SHIFT cycle
  // enters at the MSB so the result is right-aligned after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aSh    <= '0;
      r_bSh    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_aSh    <= a;
            r_bSh    <= b;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        SHIFT: begin
          r_diff   <= {w_diffBit, r_diff[WIDTH-1:1]};
          r_borrow <= w_borrowNext;
          r_aSh    <= {1'b0, r_aSh[WIDTH-1:1]};
          r_bSh    <= {1'b0, r_bSh[WIDTH-1:1]};
          r_cnt    <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    in_ready   = (r_state == IDLE);
    out_valid  = (r_state == DONE);
    diff       = r_diff;
    borrow_out = r_borrow;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing a − b over WIDTH cycles, LSB first, with a single borrow flip-flop. It is the subtract-direction companion to the team's combinational adder practice blocks. Operands enter and results leave through valid/ready handshakes so a self-checking bench or upstream sequencer can drive it back-to-back.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- in_valid  in  1  operands a, b presented.
- in_ready  out  1  block accepts operands; high only in IDLE.
- a  in  WIDTH  minuend, unsigned.
- b  in  WIDTH  subtrahend, unsigned.
- out_valid  out  1  diff/borrow_out valid; high only in DONE.
- out_ready  in  1  downstream consumes result.
- diff  out  WIDTH  (a − b) mod 2^WIDTH.
- borrow_out  out  1  1 when a < b.

## Operation
- FSM states: IDLE, SHIFT, DONE; encoding free.
- Accept: edge where state==IDLE and in_valid==1 → load a_sh<=a, b_sh<=b, borrow<=0, cnt<=0, diff<=0; state<=SHIFT. a, b ignored at all other times.
- SHIFT, each edge: a0=a_sh[0], b0=b_sh[0]; d=a0^b0^borrow; borrow<=(~a0&b0)|(~(a0^b0)&borrow); diff<={d, diff[WIDTH-1:1]}; a_sh, b_sh shift right by 1; cnt<=cnt+1.
- SHIFT exit: on the edge where cnt==WIDTH-1 (WIDTH-th shift), state<=DONE. cnt width = clog2(WIDTH)+1; never wraps.
- DONE: out_valid=1; diff and borrow_out held stable. Edge with out_ready==1 → state<=IDLE.
- borrow_out = borrow register; diff = diff register; both visible at all times but only meaningful with out_valid.
- in_valid during SHIFT/DONE: ignored, no buffering, not lost-and-flagged; upstream must hold until in_ready.
- No same-cycle pass-through: in_ready stays 0 in DONE even if out_ready==1; next accept possible one cycle after result consumed.

## Timing
- Reset (rst high at an edge): state<=IDLE, cnt<=0, borrow<=0, diff<=0, shift regs<=0. After reset: in_ready=1, out_valid=0, diff=0, borrow_out=0.
- Reset has priority over every transition, including mid-SHIFT and DONE; in-flight operation discarded, no out_valid.
- in_ready, out_valid are decoded from state (combinational from registers, no input paths).
- Latency: accept at edge E → out_valid high after edge E+WIDTH (WIDTH=8: 8 cycles).
- Max throughput: one result per WIDTH+2 cycles (accept, WIDTH shifts, 1 DONE cycle with out_ready=1).
- Backpressure: out_valid, diff, borrow_out unchanged for any number of cycles with out_ready=0.
- out_ready while not in DONE: no effect.

## Test plan
- Reset then basic: rst 2 cycles, check in_ready=1/out_valid=0/diff=0; a=0x5A, b=0x23 → after 8 cycles out_valid=1, diff=0x37, borrow_out=0.
- Borrow cases: a=0x10, b=0x20 → diff=0xF0, borrow_out=1; a=0x00, b=0x01 → diff=0xFF, borrow_out=1; a=0xFF, b=0xFF → diff=0x00, borrow_out=0.
- Backpressure and busy inputs: hold out_ready=0 for 5 cycles in DONE → diff/borrow_out constant, in_ready=0; toggle in_valid with new a, b during SHIFT → result unaffected.
- Back-to-back: in_valid held high, out_ready=1, 3 operand pairs → results in order, accepts spaced exactly WIDTH+2 cycles.
- Reset mid-operation: assert rst at 4th SHIFT cycle → next cycle in_ready=1, out_valid=0, diff=0; subsequent 0x80−0x01 → diff=0x7F, borrow_out=0.
- Random: 1000 random a, b, random out_ready stalls, WIDTH=8 and WIDTH=13 → diff==(a−b) mod 2^WIDTH, borrow_out==(a<b).
